// File: rtl/mem_rr_pkg.sv
// Shared types for the two-port round-robin memory controller:
// FSM state encoding and the latched request record.
package mem_rr_pkg;

   localparam int DWIDTH_DEF = 8;
   localparam int AWIDTH_DEF = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      STROBE  = 2'd2,
      RECOVER = 2'd3
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [AWIDTH_DEF-1:0] addr;
      logic [DWIDTH_DEF-1:0] wdata;
   } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational one-hot winner, registered
// last-grant index that moves only when a grant is actually taken.
module rr_arbiter2
   import mem_rr_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_r;

   // Winner select; under contention the requester not granted last wins
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_r ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Last-grant register, starts at 1 so requester 0 wins the first contention
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_r <= 1'b1;
      end else if (advance) begin
         last_r <= grant[1];
      end else begin
         last_r <= last_r;
      end
   end

endmodule

// File: rtl/mem_rr_ctrl.sv
// Shares one asynchronous-strobe memory between two valid/ready requesters,
// sequencing address setup, strobe and bus-hold so read/write never overlap.
module mem_rr_ctrl
   import mem_rr_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int AWIDTH = AWIDTH_DEF
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [1:0]          req_we,
   input  logic [2*AWIDTH-1:0] req_addr,
   input  logic [2*DWIDTH-1:0] req_wdata,
   output logic [1:0]          rsp_valid,
   output logic [DWIDTH-1:0]   rsp_rdata,
   output logic [AWIDTH-1:0]   mem_addr,
   output logic                mem_read,
   output logic                mem_write,
   inout  wire  [DWIDTH-1:0]   mem_data
);

   state_t              state_r;
   req_t                req_r;
   req_t                req_s;
   logic                owner_r;
   logic                oe_r;
   logic [AWIDTH-1:0]   mem_addr_r;
   logic                mem_read_r;
   logic                mem_write_r;
   logic [1:0]          rsp_valid_r;
   logic [DWIDTH-1:0]   rsp_rdata_r;
   logic [1:0]          grant_s;
   logic                accept_s;
   logic                xfer_s;
   logic                sel_s;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid   (req_valid),
      .advance (xfer_s),
      .grant   (grant_s)
   );

   // Ready is offered only in accepting states and never while reset is held
   always_comb begin
      accept_s = (state_r == IDLE) || (state_r == RECOVER);
      if (accept_s && !rst) begin
         req_ready = grant_s;
      end else begin
         req_ready = 2'b00;
      end
      xfer_s = |(req_valid & req_ready);
      sel_s  = grant_s[1];
   end

   // Capture mux for the winning requester's fields
   always_comb begin
      req_s = '0;
      if (sel_s) begin
         req_s.we    = req_we[1];
         req_s.addr  = req_addr[2*AWIDTH-1:AWIDTH];
         req_s.wdata = req_wdata[2*DWIDTH-1:DWIDTH];
      end else begin
         req_s.we    = req_we[0];
         req_s.addr  = req_addr[AWIDTH-1:0];
         req_s.wdata = req_wdata[DWIDTH-1:0];
      end
   end

   // Transaction FSM; every memory-side output is registered for the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         req_r       <= '0;
         owner_r     <= 1'b0;
         oe_r        <= 1'b0;
         mem_addr_r  <= '0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         rsp_valid_r <= 2'b00;
         rsp_rdata_r <= '0;
      end else begin
         rsp_valid_r <= 2'b00;
         case (state_r)
            IDLE, RECOVER: begin
               mem_write_r <= 1'b0;
               if (xfer_s) begin
                  req_r      <= req_s;
                  owner_r    <= sel_s;
                  mem_addr_r <= req_s.addr;
                  mem_read_r <= !req_s.we;
                  oe_r       <= req_s.we;
                  state_r    <= SETUP;
               end else begin
                  mem_read_r <= 1'b0;
                  oe_r       <= 1'b0;
                  state_r    <= IDLE;
               end
            end
            SETUP: begin
               mem_write_r <= req_r.we;
               mem_read_r  <= !req_r.we;
               state_r     <= STROBE;
            end
            STROBE: begin
               // Falling read strobe samples the bus; write data stays driven for hold
               mem_read_r  <= 1'b0;
               mem_write_r <= 1'b0;
               rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
               if (!req_r.we) begin
                  rsp_rdata_r <= mem_data;
               end else begin
                  rsp_rdata_r <= rsp_rdata_r;
               end
               state_r <= RECOVER;
            end
            default: begin
               mem_read_r  <= 1'b0;
               mem_write_r <= 1'b0;
               oe_r        <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign mem_data  = oe_r ? req_r.wdata : {DWIDTH{1'bz}};
   assign mem_addr  = mem_addr_r;
   assign mem_read  = mem_read_r;
   assign mem_write = mem_write_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_mem_rr_ctrl.sv
// Directed bench for mem_rr_ctrl with a behavioural async-strobe memory on mem_*.
module tb_mem_rr_ctrl;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_we;
   logic [9:0]  req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  rsp_valid;
   logic [7:0]  rsp_rdata;
   logic [4:0]  mem_addr;
   logic        mem_read;
   logic        mem_write;
   wire  [7:0]  mem_data;

   logic [7:0]  mem [0:31];
   logic [7:0]  last_read;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       idx;
      logic       we;
      logic [4:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;

   vec_t vecs [9];

   mem_rr_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_addr  (mem_addr),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_data  (mem_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_data = mem_read ? mem[mem_addr] : 8'hzz;

   always @(posedge mem_write) mem[mem_addr] <= mem_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bus-safety monitor: strobes exclusive, read bus carries only memory data
   always @(negedge clk) begin
      if (!rst) begin
         check("rw_overlap", 32'(mem_read & mem_write), 32'd0);
         if (mem_read) check("read_bus", 32'(mem_data), 32'(mem[mem_addr]));
      end
   end

   task automatic set_req(input logic idx, input logic we, input logic [4:0] addr, input logic [7:0] wdata);
      req_we[idx] = we;
      req_addr[int'(idx)*5 +: 5] = addr;
      req_wdata[int'(idx)*8 +: 8] = wdata;
   endtask

   // One full transaction started from IDLE at a negedge, ends at a negedge in IDLE
   task automatic run_txn(input vec_t v);
      logic [1:0] oh;
      oh = v.idx ? 2'b10 : 2'b01;
      set_req(v.idx, v.we, v.addr, v.wdata);
      req_valid = oh;
      #1;
      check("ready_grant", 32'(req_ready), 32'(oh));
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      req_addr  = ~req_addr;
      req_wdata = ~req_wdata;
      req_we    = ~req_we;
      @(negedge clk);
      check("setup_addr", 32'(mem_addr), 32'(v.addr));
      check("setup_read", 32'(mem_read), 32'(!v.we));
      check("setup_write", 32'(mem_write), 32'd0);
      check("setup_ready", 32'(req_ready), 32'd0);
      if (v.we) check("setup_wdata", 32'(mem_data), 32'(v.wdata));
      @(negedge clk);
      check("strobe_write", 32'(mem_write), 32'(v.we));
      check("strobe_read", 32'(mem_read), 32'(!v.we));
      check("strobe_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      if (!v.we) last_read = v.exp_rdata;
      check("recover_strobes", 32'({mem_read, mem_write}), 32'd0);
      check("recover_rsp", 32'(rsp_valid), 32'(oh));
      check("recover_rdata", 32'(rsp_rdata), 32'(last_read));
      @(negedge clk);
      check("idle_rsp", 32'(rsp_valid), 32'd0);
      check("idle_addr_hold", 32'(mem_addr), 32'(v.addr));
      if (v.we) check("mem_content", 32'(mem[v.addr]), 32'(v.wdata));
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 5'd3,  8'hA5, 8'h00};
      vecs[1] = '{1'b0, 1'b0, 5'd3,  8'h00, 8'hA5};
      vecs[2] = '{1'b0, 1'b1, 5'd31, 8'hFF, 8'h00};
      vecs[3] = '{1'b0, 1'b1, 5'd0,  8'h00, 8'h00};
      vecs[4] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'hFF};
      vecs[5] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00};
      vecs[6] = '{1'b1, 1'b1, 5'd7,  8'h3C, 8'h00};
      vecs[7] = '{1'b1, 1'b0, 5'd7,  8'h00, 8'h3C};
      vecs[8] = '{1'b1, 1'b1, 5'd5,  8'h77, 8'h00};

      // Reset with both requesters already valid
      rst       = 1'b1;
      req_valid = 2'b11;
      req_we    = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      last_read = 8'h00;
      set_req(1'b0, 1'b1, 5'd1, 8'h11);
      set_req(1'b1, 1'b1, 5'd2, 8'h22);
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Continuous contention: grants alternate 0,1,0,1, one accept per 3 cycles
      for (int g = 0; g < 4; g++) begin
         logic [1:0] exp_g;
         exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
         check("rr_ready", 32'(req_ready), 32'(exp_g));
         @(posedge clk);
         #1;
         if (g == 3) req_valid = 2'b00;
         @(negedge clk);
         check("rr_setup_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
         check("rr_strobe_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
         check("rr_rsp", 32'(rsp_valid), 32'(exp_g));
      end
      check("rr_ready_drop", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("rr_mem1", 32'(mem[1]), 32'h11);
      check("rr_mem2", 32'(mem[2]), 32'h22);

      // Single-requester vectors from IDLE
      for (int i = 0; i < 9; i++) run_txn(vecs[i]);

      // Read immediately followed by a write from the same requester
      set_req(1'b0, 1'b0, 5'd31, 8'h00);
      req_valid = 2'b01;
      @(posedge clk);
      #1;
      set_req(1'b0, 1'b1, 5'd4, 8'h44);
      @(negedge clk);
      check("rw_setup_read", 32'(mem_read), 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("rw_rsp_read", 32'(rsp_valid), 32'd1);
      check("rw_rdata", 32'(rsp_rdata), 32'hFF);
      check("rw_ready_recover", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      @(negedge clk);
      check("rw_setup_wr", 32'({mem_read, mem_write}), 32'd0);
      check("rw_wdata", 32'(mem_data), 32'h44);
      check("rw_addr", 32'(mem_addr), 32'd4);
      @(negedge clk);
      check("rw_strobe_wr", 32'(mem_write), 32'd1);
      @(negedge clk);
      check("rw_rsp_write", 32'(rsp_valid), 32'd1);
      check("rw_rdata_kept", 32'(rsp_rdata), 32'hFF);
      @(negedge clk);
      check("rw_mem4", 32'(mem[4]), 32'h44);

      // Reset asserted during SETUP of a write to addr 5
      set_req(1'b0, 1'b1, 5'd5, 8'h99);
      req_valid = 2'b01;
      @(posedge clk);
      #1;
      req_valid = 2'b11;
      @(negedge clk);
      check("abort_setup_drive", 32'(mem_data), 32'h99);
      #1;
      rst = 1'b1;
      #1;
      check("abort_strobes", 32'({mem_read, mem_write}), 32'd0);
      check("abort_addr", 32'(mem_addr), 32'd0);
      check("abort_rdata", 32'(rsp_rdata), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end
      req_valid = 2'b00;
      rst = 1'b0;
      last_read = 8'h00;
      @(negedge clk);
      check("abort_mem5", 32'(mem[5]), 32'h77);
      run_txn('{1'b0, 1'b0, 5'd5, 8'h00, 8'h77});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_rr_ctrl.md
# mem_rr_ctrl

Two-port round-robin controller that shares a single asynchronous-strobe memory (bidirectional data bus, level `read`/`write` strobes, write captured on the rising edge of `write`) between two synchronous requesters. Each requester sees a valid/ready request channel and a one-cycle response pulse. The block sequences address setup, strobe and bus release so that the memory never sees `read` and `write` together and the data bus is never driven from both sides. It sits between the memory instance and the two client blocks.

## Interface
- `DWIDTH`, 8, data width
- `AWIDTH`, 5, address width (memory depth 2**AWIDTH)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  2  per-requester request valid (bit i = requester i)
- `req_ready`  out  2  per-requester accept; transfer when valid&ready
- `req_we`  in  2  1 = write, 0 = read
- `req_addr`  in  2×AWIDTH  request address
- `req_wdata`  in  2×DWIDTH  write data
- `rsp_valid`  out  2  one-cycle completion pulse to owning requester
- `rsp_rdata`  out  DWIDTH  read data, valid with `rsp_valid` on a read
- `mem_addr`  out  AWIDTH  memory address
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `mem_data`  inout  DWIDTH  memory data bus, driven only during write transactions

## Operation
- FSM states: IDLE, SETUP, STROBE, RECOVER.
- Acceptance happens in IDLE or RECOVER. `req_ready[i]` is high in those states only for the arbitration winner. It is combinational from `req_valid`.
- On transfer: latch we/addr/wdata and owner index, update last-grant, go to SETUP. With no transfer: RECOVER→IDLE, IDLE→IDLE.
- Arbitration:
  - With a single valid, that requester wins.
  - With both valid, the requester not granted last wins.
  - last-grant resets to 1, so requester 0 wins the first contention.
- SETUP: `mem_addr` = latched address. Write: `mem_data` driven with wdata, strobes low. Read: `mem_read`=1, bus released. → STROBE.
- STROBE: write asserts `mem_write`=1 with address and data held. Read keeps `mem_read`=1, and `mem_data` is sampled into `rsp_rdata` at the end of STROBE. → RECOVER.
- RECOVER: both strobes low. Write keeps driving `mem_data` for hold. `rsp_valid[owner]`=1. Arbitrate again.
- `mem_read` and `mem_write` are never high in the same cycle. `mem_data` is high-Z whenever the current transaction is a read or the state is IDLE.
- `rsp_rdata` holds its last read value until the next read completes. After a write it is unchanged.
- `mem_addr` holds its last value in IDLE.

## Timing
- Reset values (immediate, asynchronous):
  - state IDLE, last-grant 1
  - `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_data` high-Z
  - `req_ready`=0 while `rst` is high, `rsp_valid`=0, `rsp_rdata`=0
- Latency: for a transfer at edge k, `rsp_valid` is high in the cycle after edge k+2.
- Back-to-back throughput: one transaction per 3 cycles (RECOVER accepts directly into SETUP).
- Idle start: one transaction per 4 cycles if the request arrives while in IDLE.
- Requester fields are needed only in the transfer cycle. The requester may present its next request right after acceptance.
- Reset during SETUP, STROBE or RECOVER:
  - strobes drop and the bus is released immediately
  - the transaction is lost, with no `rsp_valid`
  - a write aborted before STROBE does not modify memory
- Address wrap: none. Addresses are used as given, full AWIDTH range.

## Structure
- Package `mem_rr_pkg`: state enum typedef (IDLE/SETUP/STROBE/RECOVER) and a packed request struct (we, addr, wdata), both parameterized via package localparams matching the defaults.
- Sub-module `rr_arbiter2`: 2-input round-robin winner select plus last-grant register, with `clk`/`rst`, an `advance` input and a `grant` output.
- The memory itself stays outside the block. The bench instantiates it on `mem_*`.

## Test plan
- Reset, then requester 0 writes 0xA5 to addr 3, then reads addr 3 → `rsp_valid[0]` pulses at edge+3 both times, `rsp_rdata`=0xA5, `mem_write` high exactly one cycle.
- Both requesters held valid continuously from reset (r0 writes 0x11@1, r1 writes 0x22@2) → grants alternate 0,1,0,1, one accept per 3 cycles, memory holds 0x11@1 and 0x22@2.
- Write 0xFF to addr 31 and 0x00 to addr 0, read both back → 0xFF and 0x00, no aliasing.
- Read then immediate write by the same requester → assertion passes that `mem_read & mem_write` is never 1 and `mem_data` is high-Z during every read cycle.
- Write to addr 5 with reset asserted during SETUP → outputs at reset values immediately, no `rsp_valid`, addr 5 retains its prior value.
- Single requester 1 only, write 0x3C@7 → `req_ready[0]` stays 0 and `rsp_valid[1]` pulses once.
